// File: rtl/prod_accum.sv
// prod_accum: sums LEN-sample frames of signed products into a guarded accumulator and
// emits one rounded, narrowed result per frame. Define PROD_ACCUM_SAT_EN for saturation + out_sat.
module prod_accum #(
  parameter int MW    = 45,
  parameter int LEN   = 16,
  parameter int SHIFT = 0,
  parameter int OW    = 48
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [MW-1:0] prod,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data
`ifdef PROD_ACCUM_SAT_EN
  ,
  output logic          out_sat
`endif
);
  localparam int AW_ACC = MW + $clog2(LEN);
  localparam int CW     = $clog2(LEN);
  localparam int RW     = AW_ACC + 1;
  localparam int XW     = (RW > OW) ? RW : OW;

  typedef enum logic {IDLE, ACC} state_e;

  state_e                   state_q, state_d;
  logic signed [AW_ACC-1:0] acc_q, acc_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     out_valid_q, out_valid_d;
  logic [OW-1:0]            out_data_q, out_data_d;
  logic signed [AW_ACC-1:0] prod_x, sum;
  logic signed [RW-1:0]     r;
  logic signed [XW-1:0]     r_x;
  logic [OW-1:0]            narrow;
  logic                     accept, last;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign prod_x    = {{(AW_ACC-MW){prod[MW-1]}}, prod};
  assign sum       = acc_q + prod_x;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Rounding add is done one bit wider than the accumulator so it cannot overflow.
  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [RW-1:0] HALF = RW'(1) << (SHIFT - 1);
      logic signed [RW-1:0] sum_w;
      assign sum_w = RW'(sum);
      assign r     = (sum_w + HALF) >>> SHIFT;
    end else begin : g_noround
      assign r = RW'(sum);
    end
  endgenerate

  assign r_x = XW'(r);

`ifdef PROD_ACCUM_SAT_EN
  localparam logic signed [XW-1:0] HI = {{(XW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [XW-1:0] LO = ~HI;
  logic sat, out_sat_q, out_sat_d;

  always_comb begin
    sat    = 1'b0;
    narrow = r_x[OW-1:0];
    if (r_x > HI) begin
      sat    = 1'b1;
      narrow = HI[OW-1:0];
    end else if (r_x < LO) begin
      sat    = 1'b1;
      narrow = LO[OW-1:0];
    end
  end

  assign out_sat = out_sat_q;
`else
  assign narrow = r_x[OW-1:0];
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    last    = 1'b0;
    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (accept) begin
      unique case (state_q)
        IDLE: begin
          state_d = ACC;
          acc_d   = prod_x;
          cnt_d   = CW'(1);
        end
        ACC: begin
          if (cnt_q == CW'(LEN - 1)) begin
            last    = 1'b1;
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  // Pop first, then load: a same-cycle finalize overwrites the popped result and keeps valid high.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef PROD_ACCUM_SAT_EN
    out_sat_d   = out_sat_q;
`endif
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (last) begin
      out_valid_d = 1'b1;
      out_data_d  = narrow;
`ifdef PROD_ACCUM_SAT_EN
      out_sat_d   = sat;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef PROD_ACCUM_SAT_EN
      out_sat_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef PROD_ACCUM_SAT_EN
      out_sat_q   <= out_sat_d;
`endif
    end
  end
endmodule

// File: tb/tb_prod_accum.sv
// Testbench for prod_accum: three configurations share one stimulus stream and are
// compared every cycle against a frame-queue reference model.
module tb_prod_accum;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr, in_valid, out_ready;
  logic [44:0] prod;
  logic        ir0, ir1, ir2, ov0, ov1, ov2;
  logic [47:0] od0, od1;
  logic [7:0]  od2;
`ifdef PROD_ACCUM_SAT_EN
  logic        os0, os1, os2;
`endif

  prod_accum #(.MW(45), .LEN(4), .SHIFT(0), .OW(48)) u0 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(ir0), .prod(prod),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0)
`ifdef PROD_ACCUM_SAT_EN
    , .out_sat(os0)
`endif
  );
  prod_accum #(.MW(45), .LEN(2), .SHIFT(2), .OW(48)) u1 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(ir1), .prod(prod),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1)
`ifdef PROD_ACCUM_SAT_EN
    , .out_sat(os1)
`endif
  );
  prod_accum #(.MW(45), .LEN(2), .SHIFT(0), .OW(8)) u2 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(ir2), .prod(prod),
    .out_valid(ov2), .out_ready(out_ready), .out_data(od2)
`ifdef PROD_ACCUM_SAT_EN
    , .out_sat(os2)
`endif
  );

  int     LENS[3] = '{4, 2, 2};
  int     SHS[3]  = '{0, 2, 0};
  int     OWS[3]  = '{48, 48, 8};
  bit     m_pend[3];
  longint m_data[3];
  bit     m_sat[3];
  longint fq[3][$];
  longint cur_p;
  int     nvec = 0;
  int     nmis = 0;

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_pend[k] = 1'b0;
      m_data[k] = 0;
      m_sat[k]  = 1'b0;
      fq[k].delete();
    end
  endfunction

  // Frame result from the list of accepted products: sum, round half up, narrow.
  function automatic void frame_result(input int k, output longint d, output bit s);
    longint sum, r, hi, lo, m, span;
    sum = 0;
    for (int i = 0; i < fq[k].size(); i++) sum += fq[k][i];
    if (SHS[k] > 0) r = (sum + (longint'(1) <<< (SHS[k] - 1))) >>> SHS[k];
    else            r = sum;
    span = longint'(1) <<< OWS[k];
    hi   = (span >>> 1) - 1;
    lo   = -hi - 1;
`ifdef PROD_ACCUM_SAT_EN
    s = (r > hi) || (r < lo);
    d = (r > hi) ? hi : ((r < lo) ? lo : r);
`else
    s = 1'b0;
    m = r & (span - 1);
    d = (m > hi) ? m - span : m;
`endif
  endfunction

  function automatic void model_edge();
    longint d;
    bit     s, rdy;
    for (int k = 0; k < 3; k++) begin
      rdy = !m_pend[k] || out_ready;
      if (m_pend[k] && out_ready) m_pend[k] = 1'b0;
      if (clr) fq[k].delete();
      else if (in_valid && rdy) begin
        fq[k].push_back(cur_p);
        if (fq[k].size() == LENS[k]) begin
          frame_result(k, d, s);
          m_data[k] = d;
          m_sat[k]  = s;
          m_pend[k] = 1'b1;
          fq[k].delete();
        end
      end
    end
  endfunction

  function automatic logic signed [63:0] a_data(input int k);
    case (k)
      0:       return {{16{od0[47]}}, od0};
      1:       return {{16{od1[47]}}, od1};
      default: return {{56{od2[7]}}, od2};
    endcase
  endfunction

  function automatic logic a_valid(input int k);
    case (k)
      0:       return ov0;
      1:       return ov1;
      default: return ov2;
    endcase
  endfunction

  function automatic logic a_ready(input int k);
    case (k)
      0:       return ir0;
      1:       return ir1;
      default: return ir2;
    endcase
  endfunction

`ifdef PROD_ACCUM_SAT_EN
  function automatic logic a_sat(input int k);
    case (k)
      0:       return os0;
      1:       return os1;
      default: return os2;
    endcase
  endfunction
`endif

  task automatic chk(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
    nvec++;
    assert (act === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_ready(input string tag);
    for (int k = 0; k < 3; k++)
      chk($sformatf("%s.u%0d.in_ready", tag, k), 64'(a_ready(k)), 64'(!m_pend[k] || out_ready));
  endtask

  task automatic check_out(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s.u%0d.out_valid", tag, k), 64'(a_valid(k)), 64'(m_pend[k]));
      chk($sformatf("%s.u%0d.out_data", tag, k), a_data(k), m_data[k]);
`ifdef PROD_ACCUM_SAT_EN
      chk($sformatf("%s.u%0d.out_sat", tag, k), 64'(a_sat(k)), 64'(m_sat[k]));
`endif
    end
  endtask

  task automatic cyc(input bit v, input longint p, input bit c, input bit ordy, input string tag);
    in_valid  = v;
    cur_p     = p;
    prod      = p[44:0];
    clr       = c;
    out_ready = ordy;
    #1 check_ready(tag);
    @(posedge clk);
    model_edge();
    #1 check_out(tag);
  endtask

  task automatic async_rst(input string tag);
    rst = 1'b1;
    model_reset();
    #1 check_out(tag);
    check_ready(tag);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    clr      = 1'b0;
    in_valid = 1'b0;
  endtask

  function automatic longint rand_p();
    longint x;
    case ($urandom_range(0, 9))
      0:          return -(longint'(1) <<< 44);
      1:          return (longint'(1) <<< 44) - 1;
      2, 3, 4, 5: return longint'($urandom_range(0, 600)) - 300;
      default: begin
        x = longint'({$urandom(), $urandom()});
        return x >>> 23;
      end
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1; prod = '0; cur_p = 0;
    model_reset();
    @(posedge clk);
    #1;
    check_out("reset");
    check_ready("reset");
    chk("reset.u0.out_data.const", a_data(0), 0);
    chk("reset.u0.in_ready.const", 64'(ir0), 1);
    rst = 1'b0;

    // Basic frames, no bubble
    cyc(1, 3, 0, 1, "basic"); cyc(1, -5, 0, 1, "basic");
    cyc(1, 7, 0, 1, "basic"); cyc(1, 10, 0, 1, "basic");
    chk("basic.f1.valid", 64'(ov0), 1);
    chk("basic.f1.data", a_data(0), 15);
    cyc(1, 1, 0, 1, "basic"); cyc(1, 1, 0, 1, "basic");
    cyc(1, 1, 0, 1, "basic"); cyc(1, 1, 0, 1, "basic");
    chk("basic.f2.data", a_data(0), 4);

    // Rounding on the LEN=2, SHIFT=2 instance
    cyc(1, 3, 0, 1, "round"); cyc(1, 3, 0, 1, "round");
    chk("round.p6", a_data(1), 2);
    cyc(1, -3, 0, 1, "round"); cyc(1, -3, 0, 1, "round");
    chk("round.m6", a_data(1), -1);
    cyc(1, 2, 0, 1, "round"); cyc(1, 3, 0, 1, "round");
    chk("round.p5", a_data(1), 1);
    cyc(0, 0, 1, 1, "realign");

    // Narrowing on the OW=8 instance
    cyc(1, 100, 0, 1, "narrow"); cyc(1, 100, 0, 1, "narrow");
`ifdef PROD_ACCUM_SAT_EN
    chk("narrow.pos.data", a_data(2), 127);
    chk("narrow.pos.sat", 64'(os2), 1);
`else
    chk("narrow.pos.data", a_data(2), -56);
`endif
    cyc(1, -100, 0, 1, "narrow"); cyc(1, -100, 0, 1, "narrow");
`ifdef PROD_ACCUM_SAT_EN
    chk("narrow.neg.data", a_data(2), -128);
    chk("narrow.neg.sat", 64'(os2), 1);
`else
    chk("narrow.neg.data", a_data(2), 56);
`endif
    cyc(0, 0, 1, 1, "realign");

    // Back-pressure
    cyc(1, 3, 0, 1, "bp"); cyc(1, 4, 0, 1, "bp");
    chk("bp.first", a_data(2), 7);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 99, 0, 0, "bp.hold");
      chk("bp.hold.in_ready", 64'(ir2), 0);
      chk("bp.hold.data", a_data(2), 7);
    end
    cyc(0, 0, 0, 1, "bp.pop");
    chk("bp.pop.valid", 64'(ov2), 0);
    cyc(1, 2, 0, 1, "bp"); cyc(1, 2, 0, 1, "bp");
    chk("bp.second", a_data(2), 4);
    cyc(0, 0, 1, 1, "realign");

    // clr mid-frame and clr coincident with a last product
    cyc(1, 9, 0, 1, "clr"); cyc(1, 9, 0, 1, "clr");
    cyc(1, 50, 1, 1, "clr");
    cyc(1, 1, 0, 1, "clr"); cyc(1, 2, 0, 1, "clr");
    cyc(1, 3, 0, 1, "clr"); cyc(1, 4, 0, 1, "clr");
    chk("clr.frame", a_data(0), 10);
    cyc(1, 5, 0, 1, "clr"); cyc(1, 6, 0, 1, "clr"); cyc(1, 7, 0, 1, "clr");
    cyc(1, 8, 1, 1, "clr.last");
    chk("clr.last.valid", 64'(ov0), 0);

    // Reset mid-frame with results pending
    cyc(1, 1, 0, 0, "rstmid"); cyc(1, 2, 0, 0, "rstmid");
    async_rst("rstmid");
    chk("rstmid.valid", 64'(ov1), 0);
    chk("rstmid.data", a_data(1), 0);
    cyc(1, 5, 0, 1, "rstmid"); cyc(1, 5, 0, 1, "rstmid");
    cyc(1, 5, 0, 1, "rstmid"); cyc(1, 5, 0, 1, "rstmid");
    chk("rstmid.frame", a_data(0), 20);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) async_rst("rand.rst");
      else cyc(($urandom_range(0, 9) < 8), rand_p(), ($urandom_range(0, 99) < 3),
               ($urandom_range(0, 9) < 7), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
